// File: rtl/ln_input_packer.sv
// ln_input_packer: packs a stream of signed 16-bit elements into one
// 64-lane vector per row for the LayerNorm top. Rows longer than 64
// elements are cut at 64 (long error) and the remainder dropped up to
// i_s_last; rows shorter than 64 are emitted zero-padded (short error).
//
// Handshake: an element transfers on a rising edge where i_s_valid and
// o_s_ready are both high with i_rst high. o_s_ready is simply i_en, so
// the block never stalls upstream except while globally disabled.
// o_valid is a one-cycle pulse; o_data_flat and o_count hold until the
// next emitted vector.
module ln_input_packer (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_s_valid,
  input  logic [15:0]   i_s_data,
  input  logic          i_s_last,
  output logic          o_s_ready,
  output logic          o_valid,
  output logic [1023:0] o_data_flat,
  output logic [6:0]    o_count,
  output logic          o_err_short,
  output logic          o_err_long
);

  typedef enum logic {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } state_t;

  // Current FSM state; kept as a plainly named signal for checker binding.
  state_t        state;
  logic [5:0]    idx;
  logic [1023:0] asm_q;
  logic [1023:0] asm_next;
  logic          accept;
  logic          terminate;

  // Ready follows the global enable with no internal backpressure.
  assign o_s_ready = i_en;
  assign accept    = i_s_valid & i_en;
  // A row closes when the last lane is filled or upstream flags the end.
  assign terminate = (idx == 6'd63) | i_s_last;

  // Assembly register with the incoming element placed at the current
  // lane. Lanes above idx are already zero because the register is
  // cleared at every row boundary and DISCARD never writes it.
  always_comb begin
    asm_next = asm_q;
    asm_next[{idx, 4'b0000} +: 16] = i_s_data;
  end

  // Row assembly FSM, output vector registers and error pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= FILL;
      idx         <= 6'd0;
      asm_q       <= '0;
      o_valid     <= 1'b0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
      o_data_flat <= '0;
      o_count     <= 7'd0;
    end else begin
      // Pulses default low, including every cycle the block is disabled.
      o_valid     <= 1'b0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
      if (accept) begin
        case (state)
          FILL: begin
            if (terminate) begin
              o_data_flat <= asm_next;
              o_count     <= {1'b0, idx} + 7'd1;
              o_valid     <= 1'b1;
              asm_q       <= '0;
              idx         <= 6'd0;
              if (i_s_last && (idx != 6'd63)) begin
                o_err_short <= 1'b1;
              end
              if (!i_s_last && (idx == 6'd63)) begin
                o_err_long <= 1'b1;
                state      <= DISCARD;
              end
            end else begin
              asm_q <= asm_next;
              idx   <= idx + 6'd1;
            end
          end
          DISCARD: begin
            if (i_s_last) begin
              state <= FILL;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ln_input_packer.sv
// Self-checking bench for ln_input_packer. Stimulus is driven #1 after
// the rising edge; outputs are sampled on the falling edge. A row-level
// reference model turns every accepted element into expected vectors.
module tb_ln_input_packer;

  localparam int W = 1034;  // {valid, data[1023:0], count[6:0], short, long}

  logic          i_clk;
  logic          i_rst;
  logic          i_en;
  logic          i_s_valid;
  logic [15:0]   i_s_data;
  logic          i_s_last;
  logic          o_s_ready;
  logic          o_valid;
  logic [1023:0] o_data_flat;
  logic [6:0]    o_count;
  logic          o_err_short;
  logic          o_err_long;

  int n_vec;
  int n_err;
  int cyc;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];
  int            obs_cyc[$];

  // reference model state: elements of the row being collected
  logic [15:0]   m_row[$];
  bit            m_discard;
  logic [1023:0] m_last_vec;
  logic [6:0]    m_last_cnt;

  ln_input_packer dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_s_valid   (i_s_valid),
    .i_s_data    (i_s_data),
    .i_s_last    (i_s_last),
    .o_s_ready   (o_s_ready),
    .o_valid     (o_valid),
    .o_data_flat (o_data_flat),
    .o_count     (o_count),
    .o_err_short (o_err_short),
    .o_err_long  (o_err_long)
  );

  // clock / cycle counter
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // output monitor: record every cycle with any output pulse
  always @(negedge i_clk) begin
    if (o_valid || o_err_short || o_err_long) begin
      obs_q.push_back({o_valid, o_data_flat, o_count, o_err_short, o_err_long});
      obs_cyc.push_back(cyc);
    end
  end

  // reference model: a row is whatever arrives until 64 elements or last
  task automatic model_accept(input logic [15:0] d, input bit l);
    logic [1023:0] vec;
    int n;
    if (m_discard) begin
      if (l) m_discard = 0;
    end else begin
      m_row.push_back(d);
      n = m_row.size();
      if (l || n == 64) begin
        vec = '0;
        for (int i = 0; i < n; i++) vec[16*i +: 16] = m_row[i];
        exp_q.push_back({1'b1, vec, 7'(n), (l && n < 64), (!l && n == 64)});
        m_last_vec = vec;
        m_last_cnt = 7'(n);
        if (!l && n == 64) m_discard = 1;
        m_row.delete();
      end
    end
  endtask

  task automatic model_reset();
    m_row.delete();
    m_discard  = 0;
    m_last_vec = '0;
    m_last_cnt = 7'd0;
  endtask

  // driver: present one element with valid high and hold it for one edge
  task automatic drive_elem(input logic [15:0] d, input bit l);
    i_s_valid = 1'b1;
    i_s_data  = d;
    i_s_last  = l;
    @(posedge i_clk);
    if (i_en && i_rst) model_accept(d, l);
    #1;
  endtask

  task automatic idle(input int n);
    i_s_valid = 1'b0;
    i_s_last  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_en = 1'b0; i_s_valid = 1'b1; i_s_data = 16'h1234; i_s_last = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    model_reset();
    @(negedge i_clk);
    n_vec++;
    if ({o_valid, o_err_short, o_err_long, o_count} !== 10'd0 || o_data_flat !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b s=%b l=%b cnt=%0d data_nz=%b required all zero",
               o_valid, o_err_short, o_err_long, o_count, |o_data_flat);
    end
    n_vec++;
    if (o_s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_en_low: got %b required 0", o_s_ready);
    end
    i_en = 1'b1;
    #1;
    n_vec++;
    if (o_s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_en_high: got %b required 1", o_s_ready);
    end
    i_s_valid = 1'b0; i_s_last = 1'b0;
    @(posedge i_clk);
    i_rst = 1'b1;
    #1;
  endtask

  // fixed row k-100, k = 0..63
  task automatic test_full_row();
    for (int k = 0; k < 64; k++) drive_elem(16'(k - 100), k == 63);
    idle(3);
    n_vec++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
      n_err++;
      $display("FAIL full_row_count: got %0d vectors required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      n_vec++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL full_row_vec: got %h required %h", obs_q[0], exp_q[0]);
      end
      void'(obs_q.pop_front()); void'(exp_q.pop_front());
    end
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    // hold check: outputs keep the last vector
    n_vec++;
    if (o_data_flat !== m_last_vec || o_count !== m_last_cnt) begin
      n_err++;
      $display("FAIL full_row_hold: got cnt=%0d required cnt=%0d (data_eq=%b)",
               o_count, m_last_cnt, o_data_flat === m_last_vec);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 64; k++) drive_elem(16'($urandom), k == 63);
    idle(3);
    n_vec++;
    if (obs_q.size() !== 3 || exp_q.size() !== 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d vectors required 3", obs_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_vec++;
        if (obs_cyc[i] - obs_cyc[i-1] !== 64) begin
          n_err++;
          $display("FAIL b2b_spacing: got %0d cycles required 64", obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      n_vec++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL b2b_vec: got %h required %h", obs_q[0], exp_q[0]);
      end
      void'(obs_q.pop_front()); void'(exp_q.pop_front());
    end
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_short_row();
    logic [1023:0] vec;
    for (int k = 0; k < 4; k++) drive_elem(16'($urandom), 1'b0);
    drive_elem(16'h7FFF, 1'b1);
    idle(3);
    n_vec++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
      n_err++;
      $display("FAIL short_count: got %0d vectors required 1", obs_q.size());
    end else begin
      vec = obs_q[0][1032:9];
      n_vec++;
      if (vec[1023:80] !== '0 || vec[79:64] !== 16'h7FFF || obs_q[0][8:2] !== 7'd5 || obs_q[0][1:0] !== 2'b10) begin
        n_err++;
        $display("FAIL short_fields: got lane4=%h upper_nz=%b cnt=%0d errs=%b required 7fff 0 5 10",
                 vec[79:64], |vec[1023:80], obs_q[0][8:2], obs_q[0][1:0]);
      end
      n_vec++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL short_vec: got %h required %h", obs_q[0], exp_q[0]);
      end
    end
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_long_row();
    for (int k = 0; k < 70; k++) drive_elem(16'($urandom), k == 69);
    for (int k = 0; k < 64; k++) drive_elem(16'($urandom), k == 63);
    idle(3);
    n_vec++;
    if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
      n_err++;
      $display("FAIL long_count: got %0d vectors required 2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      n_vec++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL long_vec: got %h required %h", obs_q[0], exp_q[0]);
      end
      void'(obs_q.pop_front()); void'(exp_q.pop_front());
    end
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_enable_gap();
    logic [15:0] row[64];
    logic [W-1:0] plain;
    for (int k = 0; k < 64; k++) row[k] = 16'($urandom);
    for (int k = 0; k < 64; k++) drive_elem(row[k], k == 63);
    idle(2);
    plain = (obs_q.size() > 0) ? obs_q[0] : '0;
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    for (int k = 0; k < 64; k++) begin
      if (k == 20) begin
        i_en = 1'b0;
        i_s_valid = 1'b1; i_s_data = row[k]; i_s_last = 1'b0;
        #1;
        n_vec++;
        if (o_s_ready !== 1'b0) begin
          n_err++;
          $display("FAIL gap_ready: got %b required 0", o_s_ready);
        end
        for (int g = 0; g < 3; g++) begin
          @(posedge i_clk);
          #1;
        end
        i_en = 1'b1;
      end
      drive_elem(row[k], k == 63);
    end
    idle(3);
    n_vec++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
      n_err++;
      $display("FAIL gap_count: got %0d vectors required 1", obs_q.size());
    end else begin
      n_vec++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL gap_vec: got %h required %h", obs_q[0], exp_q[0]);
      end
      n_vec++;
      if (obs_q[0] !== plain) begin
        n_err++;
        $display("FAIL gap_vs_plain: got %h required %h", obs_q[0], plain);
      end
    end
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_mid_row_reset();
    for (int k = 0; k < 30; k++) drive_elem(16'($urandom), 1'b0);
    // reset edge coincides with a valid element; reset must win
    i_rst = 1'b0;
    drive_elem(16'hBEEF, 1'b1);
    i_rst = 1'b1;
    model_reset();
    @(negedge i_clk);
    n_vec++;
    if (o_count !== 7'd0 || o_data_flat !== '0 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_clear: got cnt=%0d v=%b data_nz=%b required 0 0 0",
               o_count, o_valid, |o_data_flat);
    end
    #1;
    for (int k = 0; k < 64; k++) drive_elem(16'($urandom), k == 63);
    idle(3);
    n_vec++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
      n_err++;
      $display("FAIL rst_mid_count: got %0d vectors required 1", obs_q.size());
    end else begin
      n_vec++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL rst_mid_vec: got %h required %h", obs_q[0], exp_q[0]);
      end
    end
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  // random row lengths, random valid gaps and random enable drops
  task automatic test_random();
    int len;
    bit sent;
    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 80);
      for (int k = 0; k < len; k++) begin
        sent = 0;
        while (!sent) begin
          i_en      = ($urandom_range(0, 4) != 0);
          i_s_valid = ($urandom_range(0, 3) != 0);
          i_s_data  = 16'($urandom);
          i_s_last  = (k == len - 1);
          @(posedge i_clk);
          if (i_en && i_s_valid) begin
            model_accept(i_s_data, i_s_last);
            sent = 1;
          end
          #1;
        end
      end
    end
    i_en = 1'b1;
    idle(3);
    n_vec++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL rand_count: got %0d vectors required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      n_vec++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL rand_vec: got %h required %h", obs_q[0], exp_q[0]);
      end
      void'(obs_q.pop_front()); void'(exp_q.pop_front());
    end
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
    n_vec++;
    if (o_count !== m_last_cnt || o_data_flat !== m_last_vec) begin
      n_err++;
      $display("FAIL rand_hold: got cnt=%0d required cnt=%0d (data_eq=%b)",
               o_count, m_last_cnt, o_data_flat === m_last_vec);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    i_s_valid = 1'b0; i_s_data = 16'd0; i_s_last = 1'b0;
    i_en = 1'b0; i_rst = 1'b0;
    test_reset();
    test_full_row();
    test_back_to_back();
    test_short_row();
    test_long_row();
    test_enable_gap();
    test_mid_row_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
